regfile_sb: RTL and testbench

Parametrised integer register file with an integrated multi-outstanding-write scoreboard for the RV32 core. It provides NRD combinational read ports with write-back bypass and NWB write-back ports with fixed priority. A per-register saturating pending counter replaces the single write-flag scheme, so the same destination register can have several writes in flight. It sits between ID (issue/hazard check) and the EX/MEM write-back paths.

---
 rtl/regfile_sb_if.sv | 38 +++
 rtl/regfile_sb.sv | 126 ++++++++++++
 tb/tb_regfile_sb.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_if
// Purpose  : Read / write-back / issue bundle between the register file
//            scoreboard and the ID/EX/MEM stages.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int IDX_W   = 5,
    parameter int NRD     = 2,
    parameter int NWB     = 2
);
    logic [NRD*IDX_W-1:0] rd_idx;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWB-1:0]       wb_en;
    logic [NWB*IDX_W-1:0] wb_idx;
    logic [NWB*XLEN-1:0]  wb_data;
    logic [NWB-1:0]       wb_ret;
    logic                 iss_vld;
    logic [IDX_W-1:0]     iss_rd;
    logic                 iss_rdy;
    logic [REG_NUM-1:0]   pend_vec;
    logic                 sb_err;

    modport master (
        output rd_idx, wb_en, wb_idx, wb_data, wb_ret, iss_vld, iss_rd,
        input  rd_data, rd_busy, iss_rdy, pend_vec, sb_err
    );

    modport slave (
        input  rd_idx, wb_en, wb_idx, wb_data, wb_ret, iss_vld, iss_rd,
        output rd_data, rd_busy, iss_rdy, pend_vec, sb_err
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : RV32 integer register file with write-back bypass and a
//            per-register saturating pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int              XLEN    = 32,
    parameter int              REG_NUM = 32,
    parameter int              IDX_W   = 5,
    parameter int              NRD     = 2,
    parameter int              NWB     = 2,
    parameter int              CNT_W   = 2,
    parameter int              SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = 32'h20000
) (
    input  wire logic   clk,
    input  wire logic   rst,
    regfile_sb_if.slave bus
);
    localparam int               c_dec_w   = $clog2(NWB + 1);
    localparam int               c_sum_w   = CNT_W + c_dec_w + 1;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [c_dec_w-1:0] c_dec_one = 1;

    logic [XLEN-1:0]    r_regs [REG_NUM];
    logic [CNT_W-1:0]   r_cnt  [REG_NUM];
    logic               r_sb_err;

    logic [IDX_W-1:0]   w_wb_idx  [NWB];
    logic [IDX_W-1:0]   w_rd_idx  [NRD];
    logic [XLEN-1:0]    w_rd_val  [NRD];
    logic [NRD-1:0]     w_rd_busy;
    logic [REG_NUM-1:0] w_wr_en;
    logic [XLEN-1:0]    w_wr_data [REG_NUM];
    logic [c_dec_w-1:0] w_dec     [REG_NUM];
    logic [REG_NUM-1:0] w_inc;
    logic [c_sum_w-1:0] w_sum     [REG_NUM];
    logic [CNT_W-1:0]   w_cnt_nxt [REG_NUM];
    logic [REG_NUM-1:0] w_uflow;
    logic               w_iss_rdy;

    for (genvar p = 0; p < NWB; p++) begin : g_wb
        assign w_wb_idx[p] = bus.wb_idx[p*IDX_W +: IDX_W];
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        assign w_rd_idx[p]                  = bus.rd_idx[p*IDX_W +: IDX_W];
        assign bus.rd_data[p*XLEN +: XLEN]  = w_rd_val[p];
    end

    // Only the registered count gates issue; a same-cycle retire does not free a slot.
    assign w_iss_rdy = (bus.iss_rd == '0) || (r_cnt[bus.iss_rd] != c_cnt_max);

    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            w_wr_en[r]   = 1'b0;
            w_wr_data[r] = '0;
            w_dec[r]     = '0;
            w_inc[r]     = (r != 0) && bus.iss_vld && w_iss_rdy &&
                           (bus.iss_rd == IDX_W'(r));
            // Ascending scan: the highest-index matching port wins the write.
            for (int p = 0; p < NWB; p++) begin
                if ((r != 0) && bus.wb_en[p] && (w_wb_idx[p] == IDX_W'(r))) begin
                    w_wr_en[r]   = 1'b1;
                    w_wr_data[r] = bus.wb_data[p*XLEN +: XLEN];
                    if (bus.wb_ret[p]) begin
                        w_dec[r] = w_dec[r] + c_dec_one;
                    end
                end
            end
            w_sum[r]     = c_sum_w'(r_cnt[r]) + c_sum_w'(w_inc[r]);
            w_uflow[r]   = c_sum_w'(w_dec[r]) > w_sum[r];
            w_cnt_nxt[r] = w_uflow[r] ? '0 : CNT_W'(w_sum[r] - c_sum_w'(w_dec[r]));
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            w_rd_val[p] = r_regs[w_rd_idx[p]];
            for (int q = 0; q < NWB; q++) begin
                if (bus.wb_en[q] && (w_wb_idx[q] == w_rd_idx[p])) begin
                    w_rd_val[p] = bus.wb_data[q*XLEN +: XLEN];
                end
            end
            if (w_rd_idx[p] == '0) begin
                w_rd_val[p] = '0;
            end
            w_rd_busy[p] = (w_rd_idx[p] != '0) && (w_cnt_nxt[w_rd_idx[p]] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                r_regs[r] <= (r == SP_IDX) ? SP_INIT : '0;
                r_cnt[r]  <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            for (int r = 1; r < REG_NUM; r++) begin
                if (w_wr_en[r]) begin
                    r_regs[r] <= w_wr_data[r];
                end
                r_cnt[r] <= w_cnt_nxt[r];
            end
            if (|w_uflow) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    for (genvar r = 0; r < REG_NUM; r++) begin : g_pend
        if (r == 0) begin : g_zero
            assign bus.pend_vec[r] = 1'b0;
        end else begin : g_reg
            assign bus.pend_vec[r] = (r_cnt[r] != '0);
        end
    end

    assign bus.rd_busy = w_rd_busy;
    assign bus.iss_rdy = w_iss_rdy;
    assign bus.sb_err  = r_sb_err;
endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench for regfile_sb: directed vector table plus
//            randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if bus ();
    regfile_sb dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  i0;
        logic [4:0]  i1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  ret;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        erdy;
        logic [31:0] epend;
        logic        eerr;
    } vec_t;

    vec_t tv [19];
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic        m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.wb_en   = v.en;
        bus.wb_idx  = {v.i1, v.i0};
        bus.wb_data = {v.d1, v.d0};
        bus.wb_ret  = v.ret;
        bus.iss_vld = v.iv;
        bus.iss_rd  = v.ir;
        bus.rd_idx  = {v.r1, v.r0};
    endtask

    function automatic vec_t idle_vec(input logic [4:0] r0, input logic [4:0] r1);
        vec_t v;
        v = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, r0, r1,
              32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0};
        return v;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = (r == 2) ? 32'h20000 : 32'h0;
            m_cnt[r]  = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input vec_t v, input logic [4:0] idx);
        logic [31:0] val;
        if (idx == 5'd0) return 32'h0;
        val = m_regs[idx];
        if (v.en[1] && v.i1 == idx)      val = v.d1;
        else if (v.en[0] && v.i0 == idx) val = v.d0;
        return val;
    endfunction

    task automatic rand_cycle(input int n);
        vec_t        v;
        int          nxt [32];
        logic        rdy;
        logic        acc;
        logic        uf;
        logic [1:0]  eb;
        logic [31:0] pend;
        int          d;
        v = idle_vec(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        v.en  = 2'($urandom);
        v.i0  = 5'($urandom_range(0, 7));
        v.i1  = 5'($urandom_range(0, 7));
        v.d0  = $urandom;
        v.d1  = $urandom;
        v.ret = 2'($urandom);
        v.iv  = ($urandom_range(0, 9) < 6);
        v.ir  = 5'($urandom_range(0, 7));

        rdy = (v.ir == 5'd0) || (m_cnt[v.ir] < 3);
        acc = v.iv && rdy;
        uf  = 1'b0;
        nxt[0] = 0;
        for (int r = 1; r < 32; r++) begin
            d = 0;
            if (v.en[0] && v.ret[0] && v.i0 == 5'(r)) d++;
            if (v.en[1] && v.ret[1] && v.i1 == 5'(r)) d++;
            nxt[r] = m_cnt[r] + ((acc && v.ir == 5'(r)) ? 1 : 0) - d;
            if (nxt[r] < 0) begin
                nxt[r] = 0;
                uf     = 1'b1;
            end
        end
        eb[0] = (v.r0 != 5'd0) && (nxt[v.r0] > 0);
        eb[1] = (v.r1 != 5'd0) && (nxt[v.r1] > 0);

        drive(v);
        #1;
        chk($sformatf("rnd%0d rd_data0", n), bus.rd_data[31:0],  m_read(v, v.r0));
        chk($sformatf("rnd%0d rd_data1", n), bus.rd_data[63:32], m_read(v, v.r1));
        chk($sformatf("rnd%0d rd_busy", n),  32'(bus.rd_busy),   32'(eb));
        chk($sformatf("rnd%0d iss_rdy", n),  32'(bus.iss_rdy),   32'(rdy));
        @(posedge clk);
        #1;
        if (v.en[0] && v.i0 != 5'd0) m_regs[v.i0] = v.d0;
        if (v.en[1] && v.i1 != 5'd0) m_regs[v.i1] = v.d1;
        pend = 32'h0;
        for (int r = 0; r < 32; r++) begin
            m_cnt[r] = nxt[r];
            pend[r]  = (m_cnt[r] != 0);
        end
        m_err = m_err | uf;
        chk($sformatf("rnd%0d pend_vec", n), bus.pend_vec,      pend);
        chk($sformatf("rnd%0d sb_err", n),   32'(bus.sb_err),   32'(m_err));
    endtask

    initial begin
        //          en     i0     i1     d0            d1            ret    iv    ir     r0     r1     e0            e1            eb     rdy   pend          err
        tv[0]  = '{2'b11, 5'd7, 5'd7, 32'hA5A50001, 32'h0000BEEF, 2'b00, 1'b0, 5'd0,  5'd7, 5'd2, 32'h0000BEEF, 32'h00020000, 2'b00, 1'b1, 32'h0,   1'b0};
        tv[1]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 5'd0,  5'd7, 5'd0, 32'h0000BEEF, 32'h0,        2'b00, 1'b1, 32'h0,   1'b0};
        tv[2]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b1, 5'd9,  5'd9, 5'd7, 32'h0,        32'h0000BEEF, 2'b01, 1'b1, 32'h200, 1'b0};
        tv[3]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b1, 5'd9,  5'd9, 5'd7, 32'h0,        32'h0000BEEF, 2'b01, 1'b1, 32'h200, 1'b0};
        tv[4]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b1, 5'd9,  5'd9, 5'd7, 32'h0,        32'h0000BEEF, 2'b01, 1'b1, 32'h200, 1'b0};
        tv[5]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b1, 5'd9,  5'd9, 5'd7, 32'h0,        32'h0000BEEF, 2'b01, 1'b0, 32'h200, 1'b0};
        tv[6]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 5'd10, 5'd9, 5'd7, 32'h0,        32'h0000BEEF, 2'b01, 1'b1, 32'h200, 1'b0};
        tv[7]  = '{2'b01, 5'd9, 5'd0, 32'h00000999, 32'h0,        2'b01, 1'b0, 5'd9,  5'd9, 5'd7, 32'h00000999, 32'h0000BEEF, 2'b01, 1'b0, 32'h200, 1'b0};
        tv[8]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 5'd9,  5'd9, 5'd7, 32'h00000999, 32'h0000BEEF, 2'b01, 1'b1, 32'h200, 1'b0};
        tv[9]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b1, 5'd4,  5'd4, 5'd9, 32'h0,        32'h00000999, 2'b11, 1'b1, 32'h210, 1'b0};
        tv[10] = '{2'b10, 5'd0, 5'd4, 32'h0,        32'h00000044, 2'b10, 1'b1, 5'd4,  5'd4, 5'd9, 32'h00000044, 32'h00000999, 2'b11, 1'b1, 32'h210, 1'b0};
        tv[11] = '{2'b01, 5'd4, 5'd0, 32'h00000045, 32'h0,        2'b01, 1'b0, 5'd0,  5'd4, 5'd9, 32'h00000045, 32'h00000999, 2'b10, 1'b1, 32'h200, 1'b0};
        tv[12] = '{2'b10, 5'd0, 5'd3, 32'h0,        32'h00000033, 2'b10, 1'b0, 5'd0,  5'd3, 5'd4, 32'h00000033, 32'h00000045, 2'b00, 1'b1, 32'h200, 1'b1};
        tv[13] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 5'd0,  5'd3, 5'd9, 32'h00000033, 32'h00000999, 2'b10, 1'b1, 32'h200, 1'b1};
        tv[14] = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,        2'b01, 1'b1, 5'd0,  5'd0, 5'd3, 32'h0,        32'h00000033, 2'b00, 1'b1, 32'h200, 1'b1};
        tv[15] = '{2'b01, 5'd9, 5'd0, 32'h12345678, 32'h0,        2'b00, 1'b0, 5'd0,  5'd9, 5'd0, 32'h12345678, 32'h0,        2'b01, 1'b1, 32'h200, 1'b1};
        tv[16] = '{2'b11, 5'd5, 5'd9, 32'h00000055, 32'h00000099, 2'b11, 1'b0, 5'd0,  5'd5, 5'd9, 32'h00000055, 32'h00000099, 2'b10, 1'b1, 32'h200, 1'b1};
        tv[17] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b1, 5'd6,  5'd6, 5'd0, 32'h0,        32'h0,        2'b01, 1'b1, 32'h240, 1'b1};
        tv[18] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b1, 5'd6,  5'd6, 5'd0, 32'h0,        32'h0,        2'b01, 1'b1, 32'h240, 1'b1};

        rst = 1'b1;
        drive(idle_vec(5'd0, 5'd0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(idle_vec(5'd2, 5'd5));
        #1;
        chk("reset rd_data sp", bus.rd_data[31:0],  32'h00020000);
        chk("reset rd_data r5", bus.rd_data[63:32], 32'h0);
        chk("reset pend_vec",   bus.pend_vec,       32'h0);
        chk("reset iss_rdy",    32'(bus.iss_rdy),   32'h1);
        chk("reset rd_busy",    32'(bus.rd_busy),   32'h0);
        chk("reset sb_err",     32'(bus.sb_err),    32'h0);

        for (int i = 0; i < 19; i++) begin
            drive(tv[i]);
            #1;
            chk($sformatf("row%0d rd_data0", i), bus.rd_data[31:0],  tv[i].e0);
            chk($sformatf("row%0d rd_data1", i), bus.rd_data[63:32], tv[i].e1);
            chk($sformatf("row%0d rd_busy", i),  32'(bus.rd_busy),   32'(tv[i].eb));
            chk($sformatf("row%0d iss_rdy", i),  32'(bus.iss_rdy),   32'(tv[i].erdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d pend_vec", i), bus.pend_vec,       tv[i].epend);
            chk($sformatf("row%0d sb_err", i),   32'(bus.sb_err),    32'(tv[i].eerr));
        end

        // Reset with cnt[6]=2 while a write, retire and issue to r6 are all in flight.
        rst = 1'b1;
        drive('{2'b01, 5'd6, 5'd0, 32'h00000066, 32'h0, 2'b01, 1'b1, 5'd6, 5'd6, 5'd2,
                32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(idle_vec(5'd6, 5'd2));
        bus.iss_rd = 5'd6;
        #1;
        chk("midrst rd_data r6", bus.rd_data[31:0],  32'h0);
        chk("midrst rd_data sp", bus.rd_data[63:32], 32'h00020000);
        chk("midrst pend_vec",   bus.pend_vec,       32'h0);
        chk("midrst sb_err",     32'(bus.sb_err),    32'h0);
        chk("midrst iss_rdy",    32'(bus.iss_rdy),   32'h1);
        chk("midrst rd_busy",    32'(bus.rd_busy),   32'h0);

        m_reset();
        for (int n = 0; n < 500; n++) begin
            rand_cycle(n);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
